// File: rtl/mcs4_cycle_sequencer.sv
// MCS-4 instruction-cycle sequencer: A1..X3 state ring, PC nibble drive, OPR/OPA/operand capture.
// Latency: one machine cycle = 8 states x Clk_div clk; instruction presented in X1 of its last cycle.
// Backpressure: none; the cycle never stalls, PC loads are accepted only on the X3 tick.

package mcs4_pkg;

  parameter int ADDR_W = 12;

  typedef enum logic [2:0] {
    CYC_A1 = 3'd0,
    CYC_A2 = 3'd1,
    CYC_A3 = 3'd2,
    CYC_M1 = 3'd3,
    CYC_M2 = 3'd4,
    CYC_X1 = 3'd5,
    CYC_X2 = 3'd6,
    CYC_X3 = 3'd7
  } instr_cyc_t;

  typedef enum logic [3:0] {
    OPR_NOP     = 4'h0,
    OPR_JCN     = 4'h1,
    OPR_FIM_SRC = 4'h2,
    OPR_FIN_JIN = 4'h3,
    OPR_JUN     = 4'h4,
    OPR_JMS     = 4'h5,
    OPR_INC     = 4'h6,
    OPR_ISZ     = 4'h7,
    OPR_ADD     = 4'h8,
    OPR_SUB     = 4'h9,
    OPR_LD      = 4'hA,
    OPR_XCH     = 4'hB,
    OPR_BBL     = 4'hC,
    OPR_LDM     = 4'hD,
    OPR_IO      = 4'hE,
    OPR_ACC     = 4'hF
  } opr_code_t;

endpackage

module mcs4_cycle_sequencer
  import mcs4_pkg::*;
#(
  parameter int Clk_div    = 1,
  parameter int Addr_width = 12
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic [3:0]            data_in,
  input  logic                  pc_load,
  input  logic [Addr_width-1:0] pc_load_addr,
  input  logic [7:0]            fin_addr,
  output instr_cyc_t            cyc,
  output logic                  tick,
  output logic                  sync,
  output logic                  bus_drive,
  output logic [3:0]            bus_out,
  output logic [Addr_width-1:0] pc,
  output logic                  second_word,
  output logic                  instr_valid,
  output opr_code_t             opr,
  output logic [3:0]            opa,
  output logic [7:0]            operand
);

  // Divider terminal count; Clk_div is limited to 1..16 so four bits suffice.
  localparam logic [3:0] DivLast = 4'(Clk_div - 1);
  localparam logic [Addr_width-1:0] PcOne = {{(Addr_width-1){1'b0}}, 1'b1};

  logic [3:0]            div_cnt;
  logic                  fin_cycle;
  logic [Addr_width-1:0] fetch_addr;

  // Instructions whose first word implies a second ROM cycle. FIM and FIN
  // share opcodes with SRC and JIN, distinguished only by OPA bit 0.
  function automatic logic needs_second(input opr_code_t o, input logic opa0);
    logic r;
    r = 1'b0;
    case (o)
      OPR_JCN, OPR_JUN, OPR_JMS, OPR_ISZ: r = 1'b1;
      OPR_FIM_SRC, OPR_FIN_JIN:           r = ~opa0;
      default:                            r = 1'b0;
    endcase
    return r;
  endfunction

  // Fixed ring order A1 -> ... -> X3 -> A1.
  function automatic instr_cyc_t next_cyc(input instr_cyc_t c);
    instr_cyc_t n;
    n = CYC_A1;
    case (c)
      CYC_A1:  n = CYC_A2;
      CYC_A2:  n = CYC_A3;
      CYC_A3:  n = CYC_M1;
      CYC_M1:  n = CYC_M2;
      CYC_M2:  n = CYC_X1;
      CYC_X1:  n = CYC_X2;
      CYC_X2:  n = CYC_X3;
      default: n = CYC_A1;
    endcase
    return n;
  endfunction

  // Free-running clock divider producing one state-advance tick per Clk_div clk.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      div_cnt <= 4'd0;
    end else if (div_cnt == DivLast) begin
      div_cnt <= 4'd0;
    end else begin
      div_cnt <= div_cnt + 4'd1;
    end
  end

  // Masking with rst keeps tick low while held in reset even when Clk_div=1.
  assign tick = ~rst & (div_cnt == DivLast);

  // The FIN second cycle is recognised from the held first-word OPR/OPA.
  assign fin_cycle  = second_word && (opr == OPR_FIN_JIN) && !opa[0];
  assign fetch_addr = fin_cycle ? {pc[Addr_width-1:8], fin_addr} : pc;

  assign sync      = (cyc == CYC_X3);
  assign bus_drive = (cyc == CYC_A1) || (cyc == CYC_A2) || (cyc == CYC_A3);

  // Address nibble select for the three address states; bus idles at zero otherwise.
  always_comb begin
    bus_out = 4'h0;
    case (cyc)
      CYC_A1:  bus_out = fetch_addr[3:0];
      CYC_A2:  bus_out = fetch_addr[7:4];
      CYC_A3:  bus_out = fetch_addr[11:8];
      default: bus_out = 4'h0;
    endcase
  end

  // Cycle state machine: advances on tick, captures ROM nibbles, steps and loads the PC.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cyc         <= CYC_A1;
      pc          <= '0;
      second_word <= 1'b0;
      instr_valid <= 1'b0;
      opr         <= OPR_NOP;
      opa         <= 4'h0;
      operand     <= 8'h00;
    end else if (tick) begin
      cyc <= next_cyc(cyc);
      case (cyc)
        CYC_M1: begin
          if (second_word) begin
            operand[7:4] <= data_in;
          end else begin
            opr <= opr_code_t'(data_in);
          end
        end
        CYC_M2: begin
          if (second_word) begin
            operand[3:0] <= data_in;
            instr_valid  <= 1'b1;
          end else begin
            opa <= data_in;
            // A first word that needs a second is not yet a complete instruction.
            if (!needs_second(opr, data_in[0])) begin
              operand     <= 8'h00;
              instr_valid <= 1'b1;
            end
          end
          // The FIN indirect fetch does not consume a program word.
          if (!fin_cycle) begin
            pc <= pc + PcOne;
          end
        end
        CYC_X1: begin
          instr_valid <= 1'b0;
        end
        CYC_X3: begin
          if (!second_word && needs_second(opr, opa[0])) begin
            // Jump targets are not known until word 2, so loads here are dropped.
            second_word <= 1'b1;
          end else begin
            second_word <= 1'b0;
            if (pc_load) begin
              pc <= pc_load_addr;
            end
          end
        end
        default: begin
        end
      endcase
    end
  end

endmodule

// File: tb/tb_mcs4_cycle_sequencer.sv
// Directed bench for mcs4_cycle_sequencer: per-state vector table on a Clk_div=1 instance
// driven by a small ROM model, plus hand sequences for async reset and a Clk_div=4 instance.
module tb_mcs4_cycle_sequencer;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  // Clk_div=1 instance with ROM model
  logic [3:0]  d1_data;
  logic        d1_ld;
  logic [11:0] d1_ld_addr;
  logic [7:0]  fin_addr;
  logic [2:0]  d1_cyc;
  logic        d1_tick, d1_sync, d1_bd, d1_sw, d1_iv;
  logic [3:0]  d1_bus, d1_opr, d1_opa;
  logic [11:0] d1_pc;
  logic [7:0]  d1_operand;

  mcs4_cycle_sequencer #(.Clk_div(1), .Addr_width(12)) dut1 (
    .clk(clk), .rst(rst), .data_in(d1_data), .pc_load(d1_ld), .pc_load_addr(d1_ld_addr),
    .fin_addr(fin_addr), .cyc(d1_cyc), .tick(d1_tick), .sync(d1_sync), .bus_drive(d1_bd),
    .bus_out(d1_bus), .pc(d1_pc), .second_word(d1_sw), .instr_valid(d1_iv),
    .opr(d1_opr), .opa(d1_opa), .operand(d1_operand)
  );

  // Clk_div=4 instance fed constant NOPs
  logic [3:0]  d4_data;
  logic        d4_ld;
  logic [11:0] d4_ld_addr;
  logic [2:0]  d4_cyc;
  logic        d4_tick, d4_sync, d4_bd, d4_sw, d4_iv;
  logic [3:0]  d4_bus, d4_opr, d4_opa;
  logic [11:0] d4_pc;
  logic [7:0]  d4_operand;

  mcs4_cycle_sequencer #(.Clk_div(4), .Addr_width(12)) dut4 (
    .clk(clk), .rst(rst), .data_in(d4_data), .pc_load(d4_ld), .pc_load_addr(d4_ld_addr),
    .fin_addr(fin_addr), .cyc(d4_cyc), .tick(d4_tick), .sync(d4_sync), .bus_drive(d4_bd),
    .bus_out(d4_bus), .pc(d4_pc), .second_word(d4_sw), .instr_valid(d4_iv),
    .opr(d4_opr), .opa(d4_opa), .operand(d4_operand)
  );

  // ROM model: assemble the address from A1..A3 nibbles, return high/low nibble in M1/M2
  logic [7:0]  rom1 [4096];
  logic [11:0] ra1;
  logic [7:0]  rom_byte;

  always @(posedge clk or posedge rst) begin
    if (rst) ra1 <= 12'h000;
    else if (d1_tick) begin
      case (d1_cyc)
        3'd0:    ra1[3:0]  <= d1_bus;
        3'd1:    ra1[7:4]  <= d1_bus;
        3'd2:    ra1[11:8] <= d1_bus;
        default: ;
      endcase
    end
  end

  assign rom_byte = rom1[ra1];
  assign d1_data  = (d1_cyc == 3'd3) ? rom_byte[7:4] : (d1_cyc == 3'd4) ? rom_byte[3:0] : 4'h0;

  typedef struct {
    logic        ld;
    logic [11:0] ld_addr;
    logic [2:0]  cyc;
    logic [3:0]  bus;
    logic        iv;
    logic        sw;
    logic [11:0] pc;
    logic [3:0]  opr;
    logic [3:0]  opa;
    logic [7:0]  operand;
  } vec_t;

  vec_t vecs[$];
  int checks = 0;
  int errors = 0;

  localparam logic [39:0] RESET_EXP = {3'd0, 1'b0, 1'b0, 1'b1, 4'h0, 12'h000, 1'b0, 1'b0, 4'h0, 4'h0, 8'h00};

  function automatic vec_t mkv(input logic ld, input logic [11:0] la, input logic [2:0] c,
                               input logic [3:0] b, input logic iv, input logic sw,
                               input logic [11:0] p, input logic [3:0] o, input logic [3:0] a,
                               input logic [7:0] op);
    vec_t t;
    t.ld = ld; t.ld_addr = la; t.cyc = c; t.bus = b; t.iv = iv; t.sw = sw;
    t.pc = p; t.opr = o; t.opa = a; t.operand = op;
    return t;
  endfunction

  function automatic void v(input logic ld, input logic [11:0] la, input logic [2:0] c,
                            input logic [3:0] b, input logic iv, input logic sw,
                            input logic [11:0] p, input logic [3:0] o, input logic [3:0] a,
                            input logic [7:0] op);
    vecs.push_back(mkv(ld, la, c, b, iv, sw, p, o, a, op));
  endfunction

  // Expected {cyc,tick,sync,bus_drive,bus_out,pc,second_word,instr_valid,opr,opa,operand}, running (tick=1)
  function automatic logic [39:0] expv(input vec_t e);
    return {e.cyc, 1'b1, (e.cyc == 3'd7), (e.cyc < 3'd3), e.bus, e.pc, e.sw, e.iv, e.opr, e.opa, e.operand};
  endfunction

  function automatic logic [39:0] obs1();
    return {d1_cyc, d1_tick, d1_sync, d1_bd, d1_bus, d1_pc, d1_sw, d1_iv, d1_opr, d1_opa, d1_operand};
  endfunction

  task automatic check(input string name, input logic [39:0] act, input logic [39:0] req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("FAIL %s actual=%h required=%h (cyc,tick,sync,drv,bus,pc,sw,iv,opr,opa,operand)", name, act, req);
    end
  endtask

  initial begin
    logic [2:0] es;
    logic [6:0] o4, e4;

    rst = 1'b1;
    d1_ld = 1'b0; d1_ld_addr = 12'h000;
    d4_ld = 1'b0; d4_ld_addr = 12'h000; d4_data = 4'h0;
    fin_addr = 8'h7C;
    for (int i = 0; i < 4096; i++) rom1[i] = 8'h00;
    rom1[12'h002] = 8'h40; rom1[12'h003] = 8'h25;   // JUN 0x025
    rom1[12'h025] = 8'h30;                          // FIN
    rom1[12'h07C] = 8'hAB;                          // FIN target byte
    rom1[12'h026] = 8'h4F; rom1[12'h027] = 8'hFF;   // JUN 0xFFF
    rom1[12'hFFF] = 8'h00;                          // NOP, wraps PC

    // ld, ld_addr, cyc, bus, iv, sw, pc, opr, opa, operand
    // NOP @000
    v(0,0,0,0,0,0,12'h000,0,0,0); v(0,0,1,0,0,0,12'h000,0,0,0); v(0,0,2,0,0,0,12'h000,0,0,0); v(0,0,3,0,0,0,12'h000,0,0,0);
    v(0,0,4,0,0,0,12'h000,0,0,0); v(0,0,5,0,1,0,12'h001,0,0,0); v(0,0,6,0,0,0,12'h001,0,0,0); v(0,0,7,0,0,0,12'h001,0,0,0);
    // NOP @001
    v(0,0,0,1,0,0,12'h001,0,0,0); v(0,0,1,0,0,0,12'h001,0,0,0); v(0,0,2,0,0,0,12'h001,0,0,0); v(0,0,3,0,0,0,12'h001,0,0,0);
    v(0,0,4,0,0,0,12'h001,0,0,0); v(0,0,5,0,1,0,12'h002,0,0,0); v(0,0,6,0,0,0,12'h002,0,0,0); v(0,0,7,0,0,0,12'h002,0,0,0);
    // JUN word 1 @002; load in X3 must be ignored
    v(0,0,0,2,0,0,12'h002,0,0,0); v(0,0,1,0,0,0,12'h002,0,0,0); v(0,0,2,0,0,0,12'h002,0,0,0); v(0,0,3,0,0,0,12'h002,0,0,0);
    v(0,0,4,0,0,0,12'h002,4,0,0); v(0,0,5,0,0,0,12'h003,4,0,0); v(0,0,6,0,0,0,12'h003,4,0,0); v(1,12'h555,7,0,0,0,12'h003,4,0,0);
    // JUN word 2 @003; execute loads 0x025
    v(0,0,0,3,0,1,12'h003,4,0,8'h00); v(0,0,1,0,0,1,12'h003,4,0,8'h00); v(0,0,2,0,0,1,12'h003,4,0,8'h00); v(0,0,3,0,0,1,12'h003,4,0,8'h00);
    v(0,0,4,0,0,1,12'h003,4,0,8'h20); v(0,0,5,0,1,1,12'h004,4,0,8'h25); v(0,0,6,0,0,1,12'h004,4,0,8'h25); v(1,12'h025,7,0,0,1,12'h004,4,0,8'h25);
    // FIN word 1 @025
    v(0,0,0,5,0,0,12'h025,4,0,8'h25); v(0,0,1,2,0,0,12'h025,4,0,8'h25); v(0,0,2,0,0,0,12'h025,4,0,8'h25); v(0,0,3,0,0,0,12'h025,4,0,8'h25);
    v(0,0,4,0,0,0,12'h025,3,0,8'h25); v(0,0,5,0,0,0,12'h026,3,0,8'h25); v(0,0,6,0,0,0,12'h026,3,0,8'h25); v(0,0,7,0,0,0,12'h026,3,0,8'h25);
    // FIN indirect cycle @07C; load in X2 must be ignored
    v(0,0,0,4'hC,0,1,12'h026,3,0,8'h25); v(0,0,1,7,0,1,12'h026,3,0,8'h25); v(0,0,2,0,0,1,12'h026,3,0,8'h25); v(0,0,3,0,0,1,12'h026,3,0,8'h25);
    v(0,0,4,0,0,1,12'h026,3,0,8'hA5); v(0,0,5,0,1,1,12'h026,3,0,8'hAB); v(1,12'h555,6,0,0,1,12'h026,3,0,8'hAB); v(0,0,7,0,0,1,12'h026,3,0,8'hAB);
    // JUN word 1 @026
    v(0,0,0,6,0,0,12'h026,3,0,8'hAB); v(0,0,1,2,0,0,12'h026,3,0,8'hAB); v(0,0,2,0,0,0,12'h026,3,0,8'hAB); v(0,0,3,0,0,0,12'h026,3,0,8'hAB);
    v(0,0,4,0,0,0,12'h026,4,0,8'hAB); v(0,0,5,0,0,0,12'h027,4,4'hF,8'hAB); v(0,0,6,0,0,0,12'h027,4,4'hF,8'hAB); v(0,0,7,0,0,0,12'h027,4,4'hF,8'hAB);
    // JUN word 2 @027; execute loads 0xFFF
    v(0,0,0,7,0,1,12'h027,4,4'hF,8'hAB); v(0,0,1,2,0,1,12'h027,4,4'hF,8'hAB); v(0,0,2,0,0,1,12'h027,4,4'hF,8'hAB); v(0,0,3,0,0,1,12'h027,4,4'hF,8'hAB);
    v(0,0,4,0,0,1,12'h027,4,4'hF,8'hFB); v(0,0,5,0,1,1,12'h028,4,4'hF,8'hFF); v(0,0,6,0,0,1,12'h028,4,4'hF,8'hFF); v(1,12'hFFF,7,0,0,1,12'h028,4,4'hF,8'hFF);
    // NOP @FFF, PC wraps
    v(0,0,0,4'hF,0,0,12'hFFF,4,4'hF,8'hFF); v(0,0,1,4'hF,0,0,12'hFFF,4,4'hF,8'hFF); v(0,0,2,4'hF,0,0,12'hFFF,4,4'hF,8'hFF); v(0,0,3,0,0,0,12'hFFF,4,4'hF,8'hFF);
    v(0,0,4,0,0,0,12'hFFF,0,4'hF,8'hFF); v(0,0,5,0,1,0,12'h000,0,0,0); v(0,0,6,0,0,0,12'h000,0,0,0); v(0,0,7,0,0,0,12'h000,0,0,0);
    // next fetch @000
    v(0,0,0,0,0,0,12'h000,0,0,0); v(0,0,1,0,0,0,12'h000,0,0,0); v(0,0,2,0,0,0,12'h000,0,0,0);

    repeat (2) @(negedge clk);
    #1;
    check("reset_values", obs1(), RESET_EXP);
    @(negedge clk);
    rst = 1'b0;

    for (int i = 0; i < vecs.size(); i++) begin
      d1_ld      = vecs[i].ld;
      d1_ld_addr = vecs[i].ld_addr;
      #1;
      check($sformatf("row%0d", i), obs1(), expv(vecs[i]));
      @(negedge clk);
    end

    // Now in M1 at 0x000: run LDM 5 @000, then JMS word 1 @001 up to its M1
    d1_ld = 1'b0;
    rom1[12'h000] = 8'hD5; rom1[12'h001] = 8'h5A; rom1[12'h002] = 8'hBC;
    repeat (8) @(negedge clk);
    #1;
    check("pre_reset_jms_m1", obs1(), expv(mkv(0,0,3,0,0,0,12'h001,4'hD,4'h5,8'h00)));
    #1;
    rst = 1'b1;
    #1;
    check("async_reset_mid_m1", obs1(), RESET_EXP);
    @(negedge clk);
    rst = 1'b0;
    #1;
    check("post_reset_a1", obs1(), expv(mkv(0,0,0,0,0,0,12'h000,0,0,0)));
    @(negedge clk); #1;
    check("post_reset_a2", obs1(), expv(mkv(0,0,1,0,0,0,12'h000,0,0,0)));
    @(negedge clk); #1;
    check("post_reset_a3", obs1(), expv(mkv(0,0,2,0,0,0,12'h000,0,0,0)));
    repeat (3) @(negedge clk);
    #1;
    check("post_reset_x1_ldm", obs1(), expv(mkv(0,0,5,0,1,0,12'h001,4'hD,4'h5,8'h00)));

    // Clk_div=4: every state lasts 4 clk, tick on the 4th, sync/instr_valid span whole states
    rst = 1'b1;
    @(negedge clk);
    #1;
    check("div4_reset", {28'h0, d4_cyc, d4_tick, d4_sync, d4_bd, d4_iv, d4_pc[0]},
          {28'h0, 3'd0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0});
    rst = 1'b0;
    for (int k = 0; k < 64; k++) begin
      #1;
      es = 3'((k / 4) % 8);
      o4 = {d4_cyc, d4_tick, d4_sync, d4_bd, d4_iv};
      e4 = {es, ((k % 4) == 3), (es == 3'd7), (es < 3'd3), (es == 3'd5)};
      check($sformatf("div4_clk%0d", k), {33'h0, o4}, {33'h0, e4});
      @(negedge clk);
    end
    #1;
    check("div4_pc_after_two_cycles", {25'h0, d4_cyc, d4_pc}, {25'h0, 3'd0, 12'h002});

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
